// File: rtl/srio_xfer_sched.sv
// srio_xfer_sched: splits one host transfer command into SRIO packets
// and drives the initiator's ucfg_* bus. An optional completion doorbell
// follows the last packet.
// Ports:
//   cmd_*  host command handshake and fields
//   ucfg_* initiator control bus and trigger pulses
//   srio_* initiator busy and doorbell response
//   xfer_* per-command busy, done/err pulses, sticky error code
module srio_xfer_sched #(
    parameter int unsigned MAX_PKT_BYTES = 256,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned DB_TIMEOUT    = 65535
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr_n,
    input  logic [7:0]  cmd_dest_id,
    input  logic [31:0] cmd_src_addr,
    input  logic [33:0] cmd_dest_addr,
    input  logic [23:0] cmd_len,
    input  logic        cmd_db_en,
    input  logic [15:0] cmd_db_info,
    output logic [7:0]  ucfg_dest_id,
    output logic [31:0] ucfg_src_start_addr,
    output logic [33:0] ucfg_dest_start_addr,
    output logic [8:0]  ucfg_byte_count,
    output logic [15:0] ucfg_db_info,
    output logic        ucfg_wr_n,
    output logic        ucfg_normal_trigger,
    output logic        ucfg_db_trigger,
    input  logic        srio_initial_busy,
    input  logic        srio_db_resp,
    output logic        xfer_busy,
    output logic        xfer_done,
    output logic        xfer_err,
    output logic [1:0]  xfer_err_code
);

    typedef enum logic [3:0] {
        IDLE, CHECK, ISSUE, WAIT_ACK, WAIT_DONE,
        GAP, DB_ISSUE, DB_WAIT, FINISH
    } state_t;

    localparam logic [8:0]  MAX_C    = 9'(MAX_PKT_BYTES);
    localparam logic [3:0]  GAP_INIT = (GAP_CYCLES == 0) ? 4'd0
                                     : 4'(GAP_CYCLES - 1);
    localparam logic [16:0] TO_INIT  = 17'(DB_TIMEOUT);

    state_t      state, state_d;
    logic        wr_n_q, db_en_q;
    logic [7:0]  dest_id_q;
    logic [15:0] db_info_q;
    logic [23:0] rem, rem_d;
    logic [31:0] src, src_d;
    logic [33:0] dst, dst_d;
    logic [8:0]  chunk_d;
    logic [3:0]  gap_cnt;
    logic [16:0] to_cnt;
    logic [1:0]  code_q, code_now;
    logic        enter_issue, enter_gap, enter_db;

    // Packet size is taken from the remaining count as it will be on
    // entry to ISSUE, so the ucfg bus is already valid on the trigger.
    assign chunk_d = (rem_d > {15'd0, MAX_C}) ? MAX_C : rem_d[8:0];

    assign enter_issue = (state_d == ISSUE) && (state != ISSUE);
    assign enter_gap   = (state_d == GAP) && (state != GAP);
    assign enter_db    = (state_d == DB_ISSUE) && (state != DB_ISSUE);

    // Code is visible on the pulse cycle itself, then held.
    assign xfer_err_code = xfer_err ? code_now : code_q;

    always_comb begin
        state_d             = state;
        rem_d               = rem;
        src_d               = src;
        dst_d               = dst;
        cmd_ready           = 1'b0;
        ucfg_normal_trigger = 1'b0;
        ucfg_db_trigger     = 1'b0;
        xfer_done           = 1'b0;
        xfer_err            = 1'b0;
        code_now            = 2'b00;
        xfer_busy           = (state != IDLE);
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = CHECK;
                    rem_d   = cmd_len;
                    src_d   = cmd_src_addr;
                    dst_d   = cmd_dest_addr;
                end
            end
            CHECK: begin
                if (rem == 24'd0 || rem[2:0] != 3'd0) begin
                    xfer_err = 1'b1;
                    code_now = 2'b01;
                    state_d  = IDLE;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!srio_initial_busy) begin
                    ucfg_normal_trigger = 1'b1;
                    state_d             = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (srio_initial_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!srio_initial_busy) begin
                    rem_d = rem - {15'd0, ucfg_byte_count};
                    src_d = src + {23'd0, ucfg_byte_count};
                    dst_d = dst + {25'd0, ucfg_byte_count};
                    if (rem_d != 24'd0)
                        state_d = (GAP_CYCLES == 0) ? ISSUE : GAP;
                    else
                        state_d = db_en_q ? DB_ISSUE : FINISH;
                end
            end
            GAP: begin
                if (gap_cnt == 4'd0) state_d = ISSUE;
            end
            DB_ISSUE: begin
                if (!srio_initial_busy) begin
                    ucfg_db_trigger = 1'b1;
                    state_d         = DB_WAIT;
                end
            end
            DB_WAIT: begin
                // A response on the expiry cycle still wins.
                if (srio_db_resp) begin
                    state_d = FINISH;
                end else if (to_cnt <= 17'd1) begin
                    xfer_err = 1'b1;
                    code_now = 2'b10;
                    state_d  = IDLE;
                end
            end
            FINISH: begin
                xfer_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state                <= IDLE;
            rem                  <= '0;
            src                  <= '0;
            dst                  <= '0;
            wr_n_q               <= 1'b0;
            db_en_q              <= 1'b0;
            dest_id_q            <= '0;
            db_info_q            <= '0;
            gap_cnt              <= '0;
            to_cnt               <= '0;
            code_q               <= '0;
            ucfg_dest_id         <= '0;
            ucfg_src_start_addr  <= '0;
            ucfg_dest_start_addr <= '0;
            ucfg_byte_count      <= '0;
            ucfg_db_info         <= '0;
            ucfg_wr_n            <= 1'b0;
        end else begin
            state <= state_d;
            rem   <= rem_d;
            src   <= src_d;
            dst   <= dst_d;
            if (state == IDLE && cmd_valid) begin
                wr_n_q    <= cmd_wr_n;
                db_en_q   <= cmd_db_en;
                dest_id_q <= cmd_dest_id;
                db_info_q <= cmd_db_info;
                code_q    <= 2'b00;
            end
            if (xfer_err) code_q <= code_now;
            if (enter_gap)
                gap_cnt <= GAP_INIT;
            else if (state == GAP && gap_cnt != 4'd0)
                gap_cnt <= gap_cnt - 4'd1;
            if (ucfg_db_trigger)
                to_cnt <= TO_INIT;
            else if (state == DB_WAIT && to_cnt != 17'd0)
                to_cnt <= to_cnt - 17'd1;
            if (enter_issue) begin
                ucfg_byte_count      <= chunk_d;
                ucfg_src_start_addr  <= src_d;
                ucfg_dest_start_addr <= dst_d;
                ucfg_dest_id         <= dest_id_q;
                ucfg_wr_n            <= wr_n_q;
            end
            if (enter_db) begin
                ucfg_db_info <= db_info_q;
                ucfg_dest_id <= dest_id_q;
            end
        end
    end

endmodule

// File: doc/srio_xfer_sched.md
Name: srio_xfer_sched

Overview:
- Command scheduler directly upstream of the SRIO initiator interface; drives its ucfg_* control bus and trigger pulses.
- Accepts one host transfer command of up to 16 MB and splits it into SRIO packets of at most MAX_PKT_BYTES.
- Issues each packet only after the initiator returns to idle, then optionally sends a completion doorbell and waits for its response.
- Reports done or error per command.

Parameters:
- MAX_PKT_BYTES, 256, largest packet payload in bytes; power of 2, 8..256.
- GAP_CYCLES, 4, minimum idle cycles between initiator going idle and the next trigger; 0..15.
- DB_TIMEOUT, 65535, cycles to wait for srio_db_resp after a doorbell is issued.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_wr_n  in  1  0: write local memory to remote; 1: read.
- cmd_dest_id  in  8  target device ID.
- cmd_src_addr  in  32  local memory byte address.
- cmd_dest_addr  in  34  remote byte address.
- cmd_len  in  24  transfer length in bytes.
- cmd_db_en  in  1  send a doorbell after the last packet.
- cmd_db_info  in  16  doorbell payload.
- ucfg_dest_id  out  8  to initiator.
- ucfg_src_start_addr  out  32  to initiator.
- ucfg_dest_start_addr  out  34  to initiator.
- ucfg_byte_count  out  9  to initiator.
- ucfg_db_info  out  16  to initiator.
- ucfg_wr_n  out  1  to initiator.
- ucfg_normal_trigger  out  1  one-cycle packet trigger.
- ucfg_db_trigger  out  1  one-cycle doorbell trigger.
- srio_initial_busy  in  1  initiator busy.
- srio_db_resp  in  1  one-cycle doorbell response from initiator.
- xfer_busy  out  1  high from command accept until done/err pulse.
- xfer_done  out  1  one-cycle success pulse.
- xfer_err  out  1  one-cycle failure pulse.
- xfer_err_code  out  2  01 bad length, 10 doorbell timeout; holds until the next command is accepted.

Behaviour:
- Reset values: every output 0, except cmd_ready = 1. State IDLE, all counters 0.
- States: IDLE, CHECK, ISSUE, WAIT_ACK, WAIT_DONE, GAP, DB_ISSUE, DB_WAIT, FINISH.
- IDLE: cmd_ready = 1. On accept:
  - Register all cmd fields; remaining = cmd_len; clear xfer_err_code; go to CHECK.
  - cmd_ready = 0 in every other state.
- CHECK: if cmd_len == 0 or cmd_len[2:0] != 0:
  - Pulse xfer_err with code 01; return to IDLE; no trigger issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - chunk = min(remaining, MAX_PKT_BYTES).
  - Drive ucfg_byte_count = chunk (256 encodes as 9'h100), src/dest addresses, dest_id and wr_n.
  - Same cycle: pulse ucfg_normal_trigger if srio_initial_busy = 0, then go to WAIT_ACK; otherwise hold in ISSUE.
- ucfg_* fields are registered and stable from the trigger cycle until the next ISSUE/DB_ISSUE.
- WAIT_ACK: wait for srio_initial_busy = 1 (expected the next cycle), then go to WAIT_DONE.
- WAIT_DONE: when busy = 0:
  - remaining -= chunk; src_addr += chunk (mod 2^32); dest_addr += chunk (mod 2^34).
  - If remaining != 0, go to GAP.
  - Else go to DB_ISSUE if db_en, otherwise FINISH.
- GAP: count GAP_CYCLES cycles (0 means pass through immediately), then go to ISSUE.
- DB_ISSUE:
  - Drive ucfg_db_info and ucfg_dest_id.
  - Pulse ucfg_db_trigger when busy = 0.
  - Load the timeout counter with DB_TIMEOUT; go to DB_WAIT.
- DB_WAIT:
  - srio_db_resp = 1 → FINISH.
  - Counter reaches 0 → pulse xfer_err with code 10, go to IDLE.
  - A response on the same cycle as expiry counts as success.
- FINISH: pulse xfer_done one cycle; go to IDLE. cmd_ready returns to 1 on the following cycle.
- ucfg_normal_trigger and ucfg_db_trigger are never high together, and never high while srio_initial_busy = 1.
- srio_db_resp outside DB_WAIT is ignored.
- Packet count is ceil(len/MAX_PKT_BYTES); only the last packet may be short.
- Reset mid-operation: immediate return to reset values. No pulse is emitted, and the pending command is discarded.

Test Plan:
- len = 64, wr_n = 0, db_en = 0, src = 0x1000, dest = 0x2_0000_0000 → one trigger with byte_count 64 and those addresses; xfer_done 1 cycle after busy falls, plus FINISH.
- len = 600, wr_n = 1 → three triggers with byte_count 256/256/88, dest 0x0/0x100/0x200; each trigger ≥ GAP_CYCLES after busy falls.
- len = 0 and len = 13 → xfer_err with code 01, no trigger, cmd_ready back to 1 within 2 cycles.
- len = 8, db_en = 1, db_info = 0xBEEF; srio_db_resp 10 cycles after db_trigger → db_trigger with ucfg_db_info 0xBEEF, then xfer_done.
- db_en = 1 with no response, DB_TIMEOUT = 100 → xfer_err code 10 exactly 100 cycles after db_trigger.
- Hold busy = 1 in ISSUE → no trigger until busy drops; assert reset during WAIT_DONE → all outputs return to reset values, cmd_ready = 1.
